// File: rtl/usb2_ep0_host_req.sv
// usb2_ep0_host_req: EP0 control-transfer initiator. Writes a SETUP packet plus CRC16,
// commits it, reads back the endpoint response and re-arms the endpoint.
module usb2_ep0_host_req #(
    parameter int RD_LAT   = 1,
    parameter int MAX_RESP = 64,
    parameter int TIMEOUT  = 4096
) (
    input  logic        phy_clk,
    input  logic        reset,
    input  logic        req_start,
    input  logic [7:0]  req_type,
    input  logic [7:0]  req_request,
    input  logic [15:0] req_val,
    input  logic [15:0] req_idx,
    input  logic [15:0] req_len,
    output logic        req_busy,
    output logic        req_done,
    output logic        req_err,
    output logic [9:0]  resp_len,
    output logic [7:0]  resp_data,
    output logic [8:0]  resp_index,
    output logic        resp_valid,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [8:0]  buf_out_addr,
    input  logic [7:0]  buf_out_q,
    input  logic [9:0]  buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack
);
    typedef enum logic [3:0] {
        IDLE, WAIT_READY, WRITE, COMMIT, COMMIT_REL, WAIT_DATA, READ, ARM, ARM_REL, DONE
    } state_t;

    state_t      state, nxt;
    logic [7:0]  f_type, f_req;
    logic [15:0] f_val, f_idx, f_len;
    logic [15:0] tcnt;
    logic [3:0]  wr_cnt;
    logic [10:0] rcnt;
    logic [9:0]  n, n_now;
    logic [RD_LAT-1:0] vpipe;
    logic [8:0]  ipipe [RD_LAT];
    logic [63:0] setup;
    logic [79:0] pkt;
    logic        wait_st, to, issue, rd_last;

    // Reflected bit-serial USB CRC16 over the 8 SETUP bytes, LSB of byte 0 first.
    function automatic logic [15:0] crc16(input logic [63:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? 16'hA001 : 16'h0000);
        return ~c;
    endfunction

    assign setup   = {f_len, f_idx, f_val, f_req, f_type};
    assign pkt     = {crc16(setup), setup};
    assign wait_st = state inside {WAIT_READY, COMMIT, COMMIT_REL, WAIT_DATA, ARM, ARM_REL};
    assign to      = wait_st && tcnt == 16'(TIMEOUT);
    assign n_now   = buf_out_len > 10'(MAX_RESP) ? 10'(MAX_RESP) : buf_out_len;
    assign issue   = state == READ && rcnt < {1'b0, n};
    assign rd_last = rcnt == {1'b0, n} + 11'(RD_LAT - 1);

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = req_start ? WAIT_READY : IDLE;
            WAIT_READY: nxt = to ? DONE : buf_in_ready ? WRITE : WAIT_READY;
            WRITE:      nxt = wr_cnt == 4'd9 ? COMMIT : WRITE;
            COMMIT:     nxt = to ? DONE : buf_in_commit_ack ? COMMIT_REL : COMMIT;
            COMMIT_REL: nxt = to ? DONE : !buf_in_commit_ack ? WAIT_DATA : COMMIT_REL;
            WAIT_DATA:  nxt = to ? DONE : !buf_out_hasdata ? WAIT_DATA : n_now == 10'd0 ? ARM : READ;
            READ:       nxt = rd_last ? ARM : READ;
            ARM:        nxt = to ? DONE : buf_out_arm_ack ? ARM_REL : ARM;
            ARM_REL:    nxt = to ? DONE : !buf_out_arm_ack ? DONE : ARM_REL;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    // Handshake strobes are decoded from state so an async reset drops them at once.
    always_comb begin
        req_busy          = state != IDLE;
        req_done          = state == DONE;
        buf_in_wren       = state == WRITE;
        buf_in_addr       = {5'd0, wr_cnt};
        buf_in_data       = pkt[{wr_cnt, 3'b000} +: 8];
        buf_in_commit     = state == COMMIT && !to;
        buf_in_commit_len = buf_in_commit ? 10'd10 : 10'd0;
        buf_out_arm       = state == ARM && !to;
        buf_out_addr      = rcnt[8:0];
        resp_valid        = vpipe[RD_LAT-1];
        resp_index        = ipipe[RD_LAT-1];
        resp_data         = resp_valid ? buf_out_q : 8'd0;
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            f_type   <= '0;
            f_req    <= '0;
            f_val    <= '0;
            f_idx    <= '0;
            f_len    <= '0;
            req_err  <= 1'b0;
            resp_len <= '0;
            tcnt     <= '0;
            wr_cnt   <= '0;
            rcnt     <= '0;
            n        <= '0;
            vpipe    <= '0;
            for (int i = 0; i < RD_LAT; i++) ipipe[i] <= '0;
        end else begin
            tcnt <= nxt != state ? 16'd0 : tcnt + 16'd1;
            if (state == IDLE && req_start) begin
                f_type   <= req_type;
                f_req    <= req_request;
                f_val    <= req_val;
                f_idx    <= req_idx;
                f_len    <= req_len;
                req_err  <= 1'b0;
                resp_len <= '0;
            end
            if (to) req_err <= 1'b1;
            wr_cnt <= state == WAIT_READY ? 4'd0 : (state == WRITE && wr_cnt != 4'd9) ? wr_cnt + 4'd1 : wr_cnt;
            rcnt   <= state == READ ? rcnt + 11'd1 : 11'd0;
            if (state == WAIT_DATA && buf_out_hasdata) n <= n_now;
            if (state == READ && rd_last) resp_len <= n;
            vpipe[0] <= issue;
            ipipe[0] <= rcnt[8:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                ipipe[i] <= ipipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_usb2_ep0_host_req.sv
// tb_usb2_ep0_host_req: randomized transfers against a behavioural EP0 endpoint model;
// checks SETUP bytes, CRC residual, response stream, handshakes, timeout and reset.
module tb_usb2_ep0_host_req;
    localparam int RDL  = 2;
    localparam int MAXR = 64;
    localparam int TMO  = 16;

    logic        phy_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_start = 1'b0;
    logic [7:0]  req_type = '0, req_request = '0;
    logic [15:0] req_val = '0, req_idx = '0, req_len = '0;
    logic        req_busy, req_done, req_err, resp_valid;
    logic [9:0]  resp_len;
    logic [7:0]  resp_data;
    logic [8:0]  resp_index;
    logic [8:0]  buf_in_addr, buf_out_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren, buf_in_commit, buf_out_arm;
    logic [9:0]  buf_in_commit_len;
    logic        buf_in_ready = 1'b1;
    logic        buf_in_commit_ack = 1'b0;
    logic [7:0]  buf_out_q = '0;
    logic [9:0]  buf_out_len = '0;
    logic        buf_out_hasdata = 1'b0;
    logic        buf_out_arm_ack = 1'b0;

    always #5 phy_clk = ~phy_clk;

    usb2_ep0_host_req #(.RD_LAT(RDL), .MAX_RESP(MAXR), .TIMEOUT(TMO)) dut (
        .phy_clk(phy_clk), .reset(reset), .req_start(req_start),
        .req_type(req_type), .req_request(req_request), .req_val(req_val),
        .req_idx(req_idx), .req_len(req_len), .req_busy(req_busy),
        .req_done(req_done), .req_err(req_err), .resp_len(resp_len),
        .resp_data(resp_data), .resp_index(resp_index), .resp_valid(resp_valid),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack)
    );

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Endpoint model state
    logic [7:0] rmem [512];
    logic [7:0] wbuf [16];
    logic [8:0] hist [RDL];
    logic [8:0] addr_neg = '0;
    bit ack_en = 1'b1;
    int cfg_len = 0;
    int c_seen = 0, c_left = 0, a_seen = 0, a_left = 0, d_dly = 0;

    // Monitor state
    int cyc = 0, n_wr = 0, n_commit = 0, n_arm = 0, n_done = 0;
    int start_cyc = 0, first_wr = 0, last_wr = 0, first_commit = 0;
    logic err_prev = 1'b0, err_at_done = 1'b0, err_before = 1'b0;
    logic [8:0] r_idx [$];
    logic [7:0] r_dat [$];

    // Endpoint: synchronizes commit/arm over two cycles, answers with a 3-cycle ack,
    // presents read data RDL cycles after the address.
    initial begin
        for (int i = 0; i < RDL; i++) hist[i] = '0;
        forever begin
            @(posedge phy_clk or posedge reset);
            #1;
            if (reset) begin
                c_seen = 0; c_left = 0; a_seen = 0; a_left = 0; d_dly = 0;
                buf_in_commit_ack = 1'b0;
                buf_out_arm_ack = 1'b0;
                buf_out_hasdata = 1'b0;
                buf_out_q = '0;
                for (int i = 0; i < RDL; i++) hist[i] = '0;
                continue;
            end
            for (int i = RDL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = addr_neg;
            buf_out_q = rmem[hist[RDL-1]];
            if (c_left > 0) begin
                c_left--;
                if (c_left == 0) d_dly = $urandom_range(1, 5);
            end else if (buf_in_commit && ack_en) begin
                c_seen++;
                if (c_seen == 2) begin c_left = 3; c_seen = 0; end
            end else c_seen = 0;
            buf_in_commit_ack = c_left > 0;
            if (d_dly > 0) begin
                d_dly--;
                if (d_dly == 0) begin buf_out_hasdata = 1'b1; buf_out_len = 10'(cfg_len); end
            end
            if (a_left > 0) a_left--;
            else if (buf_out_arm) begin
                a_seen++;
                if (a_seen == 2) begin a_left = 3; a_seen = 0; buf_out_hasdata = 1'b0; end
            end else a_seen = 0;
            buf_out_arm_ack = a_left > 0;
        end
    end

    always @(negedge phy_clk) begin
        cyc++;
        addr_neg = buf_out_addr;
        if (req_start && !req_busy) start_cyc = cyc;
        if (buf_in_wren) begin
            wbuf[buf_in_addr[3:0]] = buf_in_data;
            if (n_wr == 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
        end
        if (buf_in_commit) begin
            if (n_commit == 0) first_commit = cyc;
            n_commit++;
        end
        if (buf_out_arm) n_arm++;
        if (resp_valid) begin r_idx.push_back(resp_index); r_dat.push_back(resp_data); end
        if (req_done) begin n_done++; err_at_done = req_err; err_before = err_prev; end
        err_prev = req_err;
    end

    function automatic logic [15:0] residual();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 8; k++)
                c = (c >> 1) ^ ((c[0] ^ wbuf[b][k]) ? 16'hA001 : 16'h0000);
        return c;
    endfunction

    task automatic start_req(input logic [7:0] t, r, input logic [15:0] v, ix, ln, input int rl, input bit no_ack);
        for (int i = 0; i < 512; i++) rmem[i] = 8'($urandom);
        cfg_len = rl;
        ack_en = !no_ack;
        n_wr = 0; n_commit = 0; n_arm = 0; n_done = 0;
        r_idx.delete(); r_dat.delete();
        @(posedge phy_clk); #1;
        req_type = t; req_request = r; req_val = v; req_idx = ix; req_len = ln;
        req_start = 1'b1;
        @(posedge phy_clk); #1;
        req_start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] t, r, input logic [15:0] v, ix, ln,
                            input int rl, input bit poke, input bit no_ack);
        int k;
        int n_exp;
        logic [7:0] exp_b [8];
        start_req(t, r, v, ix, ln, rl, no_ack);
        check({tag, " err_clr"}, 32'(req_err), 0);
        if (poke) begin
            repeat (5) @(posedge phy_clk);
            #1;
            req_type = ~t; req_val = ~v; req_start = 1'b1;
            @(posedge phy_clk); #1;
            req_start = 1'b0;
        end
        k = 0;
        while (n_done == 0 && k < 600) begin @(posedge phy_clk); #1; k++; end
        check({tag, " done_seen"}, 32'(n_done != 0), 1);
        repeat (4) @(posedge phy_clk);
        #1;
        n_exp = no_ack ? 0 : (rl < MAXR ? rl : MAXR);
        exp_b = '{t, r, v[7:0], v[15:8], ix[7:0], ix[15:8], ln[7:0], ln[15:8]};
        check({tag, " n_done"}, 32'(n_done), 1);
        check({tag, " busy"}, 32'(req_busy), 0);
        check({tag, " n_wr"}, 32'(n_wr), 10);
        for (int i = 0; i < 8; i++) check($sformatf("%s wbyte%0d", tag, i), 32'(wbuf[i]), 32'(exp_b[i]));
        check({tag, " crc_res"}, 32'(residual()), 32'h0000B001);
        check({tag, " wr_lat"}, 32'(first_wr - start_cyc), 2);
        check({tag, " commit_lat"}, 32'(first_commit - last_wr), 1);
        check({tag, " resp_len"}, 32'(resp_len), 32'(n_exp));
        check({tag, " n_resp"}, 32'(r_idx.size()), 32'(n_exp));
        for (int i = 0; i < r_idx.size() && i < n_exp; i++) begin
            check($sformatf("%s idx%0d", tag, i), 32'(r_idx[i]), 32'(i));
            check($sformatf("%s dat%0d", tag, i), 32'(r_dat[i]), 32'(rmem[i]));
        end
        check({tag, " err"}, 32'(req_err), 32'(no_ack));
        check({tag, " err_at_done"}, 32'(err_at_done), 32'(no_ack));
        check({tag, " err_before"}, 32'(err_before), 0);
        if (no_ack) check({tag, " commit_cycles"}, 32'(n_commit), TMO);
        else check({tag, " arm_seen"}, 32'(n_arm > 0), 1);
    endtask

    task automatic reset_mid(input bit in_arm);
        int k;
        string tag;
        tag = in_arm ? "rst_arm" : "rst_read";
        start_req(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 18, 1'b0);
        k = 0;
        while (!(in_arm ? buf_out_arm : (resp_valid && resp_index == 9'd2)) && k < 300) begin
            @(posedge phy_clk); #1; k++;
        end
        check({tag, " trigger"}, 32'(k < 300), 1);
        #2 reset = 1'b1;
        #1;
        check({tag, " commit"}, 32'(buf_in_commit), 0);
        check({tag, " arm"}, 32'(buf_out_arm), 0);
        check({tag, " wren"}, 32'(buf_in_wren), 0);
        check({tag, " valid"}, 32'(resp_valid), 0);
        check({tag, " outs"}, 32'(|{req_busy, req_done, req_err, resp_len, resp_data, resp_index,
                                     buf_in_addr, buf_in_data, buf_in_commit_len, buf_out_addr}), 0);
        repeat (2) @(posedge phy_clk);
        #1 reset = 1'b0;
        run_xfer({tag, "_after"}, 8'hA1, 8'h01, 16'h0000, 16'h0002, 16'h0010, 12, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge phy_clk);
        #1;
        check("reset_busy", 32'(req_busy), 0);
        check("reset_outs", 32'(|{req_done, req_err, resp_len, resp_data, resp_index, resp_valid,
                                  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
                                  buf_in_commit_len, buf_out_addr, buf_out_arm}), 0);
        reset = 1'b0;
        run_xfer("getdesc", 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040, 18, 1'b0, 1'b0);
        run_xfer("setaddr", 8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        run_xfer("clip", 8'hC0, 8'h01, 16'h1234, 16'h5678, 16'h0064, 100, 1'b0, 1'b0);
        run_xfer("timeout", 8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0009, 9, 1'b0, 1'b1);
        run_xfer("post_tmo", 8'h80, 8'h00, 16'h0000, 16'h0000, 16'h0002, 2, 1'b0, 1'b0);
        run_xfer("busy_start", 8'h21, 8'h09, 16'h0300, 16'h0001, 16'h0020, 20, 1'b1, 1'b0);
        reset_mid(1'b0);
        reset_mid(1'b1);
        for (int i = 0; i < 10; i++)
            run_xfer($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), $urandom_range(0, 100),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
